puf_ram_ctrl: RTL

Capture and access controller for the 64-byte SRAM PUF response buffer on the FPGA. It accepts bytes from the microprocessor with a valid/ready handshake and generates write addresses 0..63 for the single-port PUF RAM. It flags frame completion, overruns and stalls. It also arbitrates the one RAM port between the capture writer and a readout requester, such as a key-generation or debug reader.

---
 rtl/puf_ram_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/puf_ram_ctrl.sv
// Capture and readout controller for the SRAM PUF response buffer.
// A capture writer fills DEPTH bytes into a single-port RAM; a readout
// requester shares the same port and gets it only when no write occurs.
// TIMEOUT must be at least 2.
module puf_ram_ctrl #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                uprocessor_clk,
    input  logic                rst,
    input  logic                cap_start,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q,
    output logic                busy,
    output logic                frame_done,
    output logic [ADDR_W:0]     byte_cnt,
    output logic                overrun_err,
    output logic                timeout_err
);

    localparam int STALL_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [ADDR_W-1:0]    wr_ptr_r;
    logic [ADDR_W:0]      byte_cnt_r;
    logic [STALL_W-1:0]   stall_r;
    logic                 busy_r;
    logic                 frame_done_r;
    logic                 overrun_r;
    logic                 timeout_r;
    logic                 rd_valid_r;

    logic                 capture_s;
    logic                 wr_fire_s;
    logic                 last_byte_s;
    logic                 stall_max_s;
    logic                 rd_gnt_s;
    logic [ADDR_W-1:0]    ram_addr_s;

    // A restart pulse wins over a byte in the same cycle, so that byte never writes.
    assign capture_s   = (state_r == ST_CAPTURE);
    assign wr_fire_s   = capture_s & din_valid & ~cap_start;
    assign last_byte_s = (wr_ptr_r == ADDR_W'(DEPTH - 1));
    assign stall_max_s = (stall_r == STALL_W'(TIMEOUT - 1));

    // RAM port arbitration: capture writes always win, reads fill the gaps.
    always_comb begin
        rd_gnt_s   = rd_req & ~wr_fire_s;
        ram_addr_s = wr_ptr_r;
        if (wr_fire_s) begin
            ram_addr_s = wr_ptr_r;
        end else if (rd_gnt_s) begin
            ram_addr_s = rd_addr;
        end else begin
            ram_addr_s = wr_ptr_r;
        end
    end

    assign din_ready = capture_s;
    assign rd_gnt    = rd_gnt_s;
    assign ram_addr  = ram_addr_s;
    assign ram_wdata = din;
    assign ram_wren  = wr_fire_s;
    // RAM data arrives the cycle after the grant, aligned with rd_valid.
    assign rd_data   = ram_q;

    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign byte_cnt    = byte_cnt_r;
    assign overrun_err = overrun_r;
    assign timeout_err = timeout_r;
    assign rd_valid    = rd_valid_r;

    // Next-state logic for the capture sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cap_start) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CAPTURE: begin
                if (cap_start) begin
                    state_next_s = ST_CAPTURE;
                end else if (din_valid) begin
                    state_next_s = last_byte_s ? ST_DONE : ST_CAPTURE;
                end else if (stall_max_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered busy flag that tracks the next state.
    always_ff @(posedge uprocessor_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_CAPTURE);
        end
    end

    // Write pointer, byte count, stall timer and sticky status flags.
    always_ff @(posedge uprocessor_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            byte_cnt_r   <= '0;
            stall_r      <= '0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (cap_start) begin
            wr_ptr_r     <= '0;
            byte_cnt_r   <= '0;
            stall_r      <= '0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (wr_fire_s) begin
            wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
            byte_cnt_r <= byte_cnt_r + (ADDR_W + 1)'(1);
            stall_r    <= '0;
            if (last_byte_s) begin
                frame_done_r <= 1'b1;
            end else begin
                frame_done_r <= frame_done_r;
            end
        end else if (capture_s) begin
            if (stall_max_s) begin
                stall_r   <= '0;
                timeout_r <= 1'b1;
            end else begin
                stall_r <= stall_r + STALL_W'(1);
            end
        end else begin
            if (din_valid) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // One rd_valid pulse per grant, one cycle later.
    always_ff @(posedge uprocessor_clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_gnt_s;
        end
    end

endmodule
